// File: rtl/uart_tx_response_scheduler.sv
// Response scheduler for the UART transmitter.
// ALU results and register reads are queued in a small FIFO as {len, payload}.
// Each entry is sent as len frames. Every frame is handshaked on the synchronised busy flag.
// The receiver controller is enabled only while nothing remains to send.
module uart_tx_response_scheduler #(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_BYTES = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int MSB_FIRST    = 0,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [RESULT_BYTES*DATA_WIDTH-1:0] alu_result,
  input  logic                               alu_result_valid,
  input  logic [DATA_WIDTH-1:0]              read_data,
  input  logic                               read_data_valid,
  input  logic                               transmitter_busy_sync,
  output logic [DATA_WIDTH-1:0]              transmitter_parallel_data,
  output logic                               transmitter_parallel_data_valid,
  output logic                               uart_receiver_controller_en,
  output logic                               fifo_full,
  output logic                               overflow,
  output logic [7:0]                         retry_count
);
  localparam int PW = RESULT_BYTES * DATA_WIDTH;
  localparam int LW = $clog2(RESULT_BYTES + 1);
  localparam int EW = LW + PW;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(BUSY_TIMEOUT);
  localparam logic [TW-1:0] T_LAST   = TW'(BUSY_TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [LW-1:0] LEN_ALU  = LW'(RESULT_BYTES);
  localparam logic [LW-1:0] LEN_RD   = LW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state, state_nxt;

  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr, rd_after;
  logic                  empty, full, wr_req, pop, push, en_nxt;
  logic [EW-1:0]         wr_entry, head;
  logic [PW-1:0]         shift_reg;
  logic [LW-1:0]         byte_cnt;
  logic [TW-1:0]         tmo_cnt;
  logic [DATA_WIDTH-1:0] cur_byte;

  assign fifo_full                       = full;
  assign transmitter_parallel_data_valid = (state == SEND);

  // FIFO status, write arbitration (ALU wins a collision) and the entry to store
  always_comb begin
    empty  = (wr_ptr == rd_ptr);
    full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    wr_req = alu_result_valid | read_data_valid;
    pop    = (state == IDLE) && !empty;
    push   = wr_req && (!full || pop);
    head   = mem[rd_ptr[AW-1:0]];
    if (alu_result_valid) wr_entry = {LEN_ALU, alu_result};
    else                  wr_entry = {LEN_RD, PW'(read_data)};
  end

  // Queue storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

  // Pointers and the sticky overflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if ((alu_result_valid && read_data_valid) || (wr_req && !push)) overflow <= 1'b1;
    end
  end

  // Next-state logic for the frame sequencer
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!empty) state_nxt = LOAD;
      LOAD:      state_nxt = SEND;
      SEND:      state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (transmitter_busy_sync)  state_nxt = WAIT_DONE;
        else if (tmo_cnt == T_LAST) state_nxt = SEND;
      end
      WAIT_DONE: if (!transmitter_busy_sync) state_nxt = (byte_cnt == LEN_RD) ? IDLE : LOAD;
      default:   state_nxt = IDLE;
    endcase
  end

  // Byte to present: low byte of the shifter, or byte index byte_cnt-1 when MSB first
  always_comb begin
    cur_byte = shift_reg[DATA_WIDTH-1:0];
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < RESULT_BYTES; i++) begin
        if (byte_cnt == LW'(i + 1)) cur_byte = shift_reg[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // The receiver enable looks ahead: the block is going idle with nothing left queued
  always_comb begin
    rd_after = pop ? rd_ptr + PTR_ONE : rd_ptr;
    en_nxt   = (state_nxt == IDLE) && (rd_after == wr_ptr) && !wr_req;
  end

  // Sequencer state, byte and timeout counters, retry counter and the frame data register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                       <= IDLE;
      byte_cnt                    <= '0;
      tmo_cnt                     <= '0;
      retry_count                 <= '0;
      transmitter_parallel_data   <= '0;
      uart_receiver_controller_en <= 1'b1;
    end else begin
      state                       <= state_nxt;
      uart_receiver_controller_en <= en_nxt;
      case (state)
        IDLE:      if (!empty) byte_cnt <= head[EW-1 -: LW];
        LOAD:      transmitter_parallel_data <= cur_byte;
        SEND:      tmo_cnt <= '0;
        WAIT_BUSY: begin
          if (!transmitter_busy_sync) begin
            if (tmo_cnt == T_LAST) begin
              if (retry_count != 8'hFF) retry_count <= retry_count + 8'd1;
            end else begin
              tmo_cnt <= tmo_cnt + TMO_ONE;
            end
          end
        end
        WAIT_DONE: if (!transmitter_busy_sync) byte_cnt <= byte_cnt - LEN_RD;
        default:   ;
      endcase
    end
  end

  // Payload shifter: loaded on pop, shifted down after each completed frame when LSB first
  always_ff @(posedge clk) begin
    if (state == IDLE && !empty)
      shift_reg <= head[PW-1:0];
    else if (state == WAIT_DONE && !transmitter_busy_sync && MSB_FIRST == 0)
      shift_reg <= shift_reg >> DATA_WIDTH;
  end

endmodule

// File: tb/tb_uart_tx_response_scheduler.sv
// Bench for uart_tx_response_scheduler.
// dut0 uses the default parameters. dut1 uses three result bytes sent MSB first.
module tb_uart_tx_response_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] alu0;
  logic        alu_v0, rd_v0, busy0, valid0, en0, full0, ovf0;
  logic [7:0]  rd0, data0, retry0;
  logic [23:0] alu1;
  logic        alu_v1, rd_v1, busy1, valid1, en1, full1, ovf1;
  logic [7:0]  rd1, data1, retry1;

  uart_tx_response_scheduler dut0 (
    .clk(clk), .reset(reset), .alu_result(alu0), .alu_result_valid(alu_v0),
    .read_data(rd0), .read_data_valid(rd_v0), .transmitter_busy_sync(busy0),
    .transmitter_parallel_data(data0), .transmitter_parallel_data_valid(valid0),
    .uart_receiver_controller_en(en0), .fifo_full(full0), .overflow(ovf0),
    .retry_count(retry0));

  uart_tx_response_scheduler #(.RESULT_BYTES(3), .MSB_FIRST(1)) dut1 (
    .clk(clk), .reset(reset), .alu_result(alu1), .alu_result_valid(alu_v1),
    .read_data(rd1), .read_data_valid(rd_v1), .transmitter_busy_sync(busy1),
    .transmitter_parallel_data(data1), .transmitter_parallel_data_valid(valid1),
    .uart_receiver_controller_en(en1), .fifo_full(full1), .overflow(ovf1),
    .retry_count(retry1));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pcyc  = 0;
  int resp_mode = 0;   // 0: busy low, 1: auto transmitter model, 2: busy held high
  int rcnt0 = 0;
  int rcnt1 = 0;
  logic [7:0] got0[$];
  int         scyc0[$];
  logic [7:0] got1[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every launched frame and the cycle it was strobed in
  always @(negedge clk) begin
    if (valid0) begin got0.push_back(data0); scyc0.push_back(cyc); end
    if (valid1) got1.push_back(data1);
  end

  // Transmitter model: busy rises 2 clk after a strobe and stays high for 10 clk
  always @(negedge clk) begin
    if (resp_mode == 0) begin
      rcnt0 = 0; rcnt1 = 0; busy0 = 1'b0; busy1 = 1'b0;
    end else if (resp_mode == 2) begin
      rcnt0 = 0; rcnt1 = 0; busy0 = 1'b1; busy1 = 1'b1;
    end else begin
      if (rcnt0 == 0 && valid0) rcnt0 = 12; else if (rcnt0 > 0) rcnt0--;
      if (rcnt1 == 0 && valid1) rcnt1 = 12; else if (rcnt1 > 0) rcnt1--;
      busy0 = (rcnt0 >= 1 && rcnt0 <= 10);
      busy1 = (rcnt1 >= 1 && rcnt1 <= 10);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse0(input logic a, input logic r, input logic [15:0] av, input logic [7:0] rv);
    @(negedge clk);
    alu0 = av; rd0 = rv; alu_v0 = a; rd_v0 = r; pcyc = cyc;
    @(negedge clk);
    alu_v0 = 1'b0; rd_v0 = 1'b0;
  endtask

  task automatic wait_frames0(input int base, input int n, input int budget);
    int k = 0;
    while (!((got0.size() >= base + n) && en0 && rcnt0 == 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) begin
      total++; bad++;
      $display("FAIL wait_frames0: only %0d of %0d frames before budget", got0.size() - base, n);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic do_reset();
    resp_mode = 0;
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic        is_alu;
    logic [15:0] alu;
    logic [7:0]  rd;
    int          nfr;
    logic [7:0]  f0;
    logic [7:0]  f1;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int base, base2, k;
    vecs[0] = '{1'b1, 16'hE7A6, 8'h00, 2, 8'hA6, 8'hE7};
    vecs[1] = '{1'b0, 16'h0000, 8'h79, 1, 8'h79, 8'h00};
    vecs[2] = '{1'b1, 16'h00FF, 8'h00, 2, 8'hFF, 8'h00};
    vecs[3] = '{1'b0, 16'h0000, 8'h80, 1, 8'h80, 8'h00};
    vecs[4] = '{1'b1, 16'h8001, 8'h00, 2, 8'h01, 8'h80};

    reset = 1'b1;
    alu0 = '0; alu_v0 = 1'b0; rd0 = '0; rd_v0 = 1'b0;
    alu1 = '0; alu_v1 = 1'b0; rd1 = '0; rd_v1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", valid0, 1'b0);
    check("rst_data", data0, 8'h00);
    check("rst_en", en0, 1'b1);
    check("rst_full", full0, 1'b0);
    check("rst_ovf", ovf0, 1'b0);
    check("rst_retry", retry0, 8'h00);
    check("rst_en1", en1, 1'b1);
    check("rst_full1", full1, 1'b0);
    check("rst_ovf1", ovf1, 1'b0);
    check("rst_retry1", retry1, 8'h00);
    reset = 1'b0;
    @(negedge clk);

    // Table of single transactions with the transmitter model answering
    resp_mode = 1;
    for (int i = 0; i < 5; i++) begin
      base = got0.size();
      pulse0(vecs[i].is_alu, !vecs[i].is_alu, vecs[i].alu, vecs[i].rd);
      wait_frames0(base, vecs[i].nfr, 400);
      check($sformatf("vec%0d_count", i), got0.size() - base, vecs[i].nfr);
      if (got0.size() > base) begin
        check($sformatf("vec%0d_f0", i), got0[base], vecs[i].f0);
        check($sformatf("vec%0d_latency", i), scyc0[base] - pcyc, 3);
      end
      if (vecs[i].nfr == 2 && got0.size() > base + 1)
        check($sformatf("vec%0d_f1", i), got0[base+1], vecs[i].f1);
      check($sformatf("vec%0d_en", i), en0, 1'b1);
      check($sformatf("vec%0d_ovf", i), ovf0, 1'b0);
    end

    // Three-byte result, most significant byte first
    base = got1.size();
    @(negedge clk); alu1 = 24'h123456; alu_v1 = 1'b1;
    @(negedge clk); alu_v1 = 1'b0;
    k = 0;
    while (!((got1.size() >= base + 3) && en1 && rcnt1 == 0) && k < 600) begin
      @(negedge clk); k++;
    end
    check("msb_wait", (k < 600), 1'b1);
    repeat (10) @(negedge clk);
    check("msb_count", got1.size() - base, 3);
    if (got1.size() >= base + 3) begin
      check("msb_f0", got1[base], 8'h12);
      check("msb_f1", got1[base+1], 8'h34);
      check("msb_f2", got1[base+2], 8'h56);
    end
    check("msb_en", en1, 1'b1);

    // Collision: ALU wins, read dropped
    base = got0.size();
    pulse0(1'b1, 1'b1, 16'h0102, 8'hFF);
    wait_frames0(base, 2, 400);
    check("both_count", got0.size() - base, 2);
    if (got0.size() >= base + 2) begin
      check("both_f0", got0[base], 8'h02);
      check("both_f1", got0[base+1], 8'h01);
    end
    check("both_ovf", ovf0, 1'b1);

    do_reset();
    check("ovf_cleared", ovf0, 1'b0);

    // Fill the FIFO while the transmitter is stuck busy
    resp_mode = 2;
    base = got0.size();
    pulse0(1'b0, 1'b1, 16'h0000, 8'hAA);
    repeat (8) @(negedge clk);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 4) check("fifo_not_full_3", full0, 1'b0);
      if (i == 5) begin
        check("fifo_full_4", full0, 1'b1);
        check("no_ovf_4", ovf0, 1'b0);
      end
      rd0 = 8'(i); rd_v0 = 1'b1;
    end
    @(negedge clk); rd_v0 = 1'b0;
    check("fifo_ovf", ovf0, 1'b1);
    check("fifo_still_full", full0, 1'b1);
    check("fifo_en_low", en0, 1'b0);
    resp_mode = 1;
    wait_frames0(base, 5, 1500);
    check("fifo_count", got0.size() - base, 5);
    if (got0.size() >= base + 5) begin
      check("fifo_f0", got0[base], 8'hAA);
      for (int i = 1; i <= 4; i++)
        check($sformatf("fifo_f%0d", i), got0[base+i], 8'(i));
    end
    check("fifo_drained", full0, 1'b0);
    check("fifo_en", en0, 1'b1);

    // Busy never rises: re-issue every BUSY_TIMEOUT+1 clk, retry_count saturates
    do_reset();
    base = got0.size();
    pulse0(1'b0, 1'b1, 16'h0000, 8'h5A);
    k = 0;
    while (got0.size() < base + 3 && k < 400) begin @(negedge clk); k++; end
    check("tmo_wait", (k < 400), 1'b1);
    if (got0.size() >= base + 3) begin
      check("tmo_period1", scyc0[base+1] - scyc0[base], 65);
      check("tmo_period2", scyc0[base+2] - scyc0[base+1], 65);
      check("tmo_data1", got0[base+1], 8'h5A);
      check("tmo_data2", got0[base+2], 8'h5A);
    end
    check("tmo_retry2", retry0, 8'd2);
    repeat (260 * 65) @(negedge clk);
    check("tmo_retry_sat", retry0, 8'hFF);
    check("tmo_data_last", got0[got0.size()-1], 8'h5A);
    check("tmo_en_low", en0, 1'b0);

    // Reset during WAIT_DONE of the first byte of 16'hBEEF
    do_reset();
    resp_mode = 1;
    base = got0.size();
    pulse0(1'b1, 1'b0, 16'hBEEF, 8'h00);
    k = 0;
    while (got0.size() < base + 1 && k < 50) begin @(negedge clk); k++; end
    check("rst_mid_wait", (k < 50), 1'b1);
    repeat (4) @(negedge clk);
    check("rst_mid_data_before", data0, 8'hEF);
    check("rst_mid_busy", busy0, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_valid", valid0, 1'b0);
    check("rst_mid_data", data0, 8'h00);
    check("rst_mid_en", en0, 1'b1);
    check("rst_mid_retry", retry0, 8'h00);
    @(negedge clk); reset = 1'b0;
    base2 = got0.size();
    repeat (60) @(negedge clk);
    check("rst_mid_no_frames", got0.size() - base2, 0);
    check("rst_mid_en_after", en0, 1'b1);
    check("rst_mid_data_after", data0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
